bcd_share_arbiter: RTL



---
 rtl/bcd_arb_pkg.sv | 18 +
 rtl/bcd_share_arbiter_rr_pick.sv | 36 +++
 rtl/bin2bcd.sv | 27 ++
 rtl/bcd_share_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/bcd_arb_pkg.sv
// Shared types and constants for the BCD converter-sharing arbiter.
package bcd_arb_pkg;

  localparam int unsigned BIN_W  = 10;
  localparam int unsigned BCD_W  = 12;
  // Converter output carries a thousands digit on top of the three we return.
  localparam int unsigned CONV_W = 16;

  localparam logic [BIN_W-1:0] BCD_MAX = 10'd999;
  localparam logic [BCD_W-1:0] BCD_SAT = 12'h999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/bcd_share_arbiter_rr_pick.sv
// Round-robin one-hot picker: first asserted request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]                          req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0]  ptr,
  output logic [N-1:0]                          gnt_onehot,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0]  gnt_idx
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  int unsigned      idx;
  logic [IDX_W-1:0] sel;
  logic             found;

  // Scan N positions starting at ptr; the first requester seen wins.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    idx        = 0;
    sel        = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      sel = IDX_W'(idx);
      if (!found && req[sel]) begin
        found           = 1'b1;
        gnt_onehot[sel] = 1'b1;
        gnt_idx         = sel;
      end
    end
  end

endmodule

// File: rtl/bin2bcd.sv
// Combinational 10-bit binary to 4-digit BCD converter (double dabble).
module bin2bcd
  import bcd_arb_pkg::*;
(
  input  logic [BIN_W-1:0]  bin,
  output logic [CONV_W-1:0] bcd
);

  logic [BIN_W-1:0]  sh;
  logic [CONV_W-1:0] acc;

  // Add-3 on digits >= 5, then shift in the next binary bit, MSB first.
  always_comb begin
    sh  = bin;
    acc = '0;
    for (int unsigned i = 0; i < BIN_W; i++) begin
      if (acc[3:0]   >= 4'd5) acc[3:0]   = acc[3:0]   + 4'd3;
      if (acc[7:4]   >= 4'd5) acc[7:4]   = acc[7:4]   + 4'd3;
      if (acc[11:8]  >= 4'd5) acc[11:8]  = acc[11:8]  + 4'd3;
      if (acc[15:12] >= 4'd5) acc[15:12] = acc[15:12] + 4'd3;
      acc = {acc[CONV_W-2:0], sh[BIN_W-1]};
      sh  = {sh[BIN_W-2:0], 1'b0};
    end
    bcd = acc;
  end

endmodule

// File: rtl/bcd_share_arbiter.sv
// Round-robin arbiter sharing one bin2bcd converter among N_REQ requesters.
// Optional saturation of operands above 999: define BCD_ARB_SAT_EN.
module bcd_share_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned BIN_W = 10,
  parameter int unsigned BCD_W = 12
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [N_REQ-1:0]                             req_valid,
  output logic [N_REQ-1:0]                             req_ready,
  input  logic [N_REQ*BIN_W-1:0]                       req_bin,
  output logic                                         rsp_valid,
  input  logic                                         rsp_ready,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] rsp_id,
  output logic [BCD_W-1:0]                             rsp_bcd,
  output logic                                         rsp_ovf,
  output logic                                         busy
);

  import bcd_arb_pkg::arb_state_t;
  import bcd_arb_pkg::IDLE;
  import bcd_arb_pkg::CONV;
  import bcd_arb_pkg::RESP;
  import bcd_arb_pkg::CONV_W;

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [BIN_W-1:0]  op_q, op_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ovf_q, ovf_d;

  logic [N_REQ-1:0]  gnt_onehot;
  logic [ID_W-1:0]   gnt_idx;
  logic [CONV_W-1:0] conv_bcd;
  logic [BCD_W-1:0]  bcd_c;
  logic              ovf_c;
  logic              unused_conv_hi;

  rr_pick #(.N(N_REQ)) u_pick (
    .req        (req_valid),
    .ptr        (ptr_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx)
  );

  bin2bcd u_conv (
    .bin (op_q),
    .bcd (conv_bcd)
  );

  // Thousands digit is only meaningful for operands above 999 and is dropped.
  assign unused_conv_hi = ^conv_bcd[CONV_W-1:BCD_W];

`ifdef BCD_ARB_SAT_EN
  // Clamp out-of-range operands to 999 and flag them.
  assign ovf_c = (op_q > bcd_arb_pkg::BCD_MAX);
  assign bcd_c = ovf_c ? bcd_arb_pkg::BCD_SAT : conv_bcd[BCD_W-1:0];
`else
  // Pass the low three digits through; no range check.
  assign ovf_c = 1'b0;
  assign bcd_c = conv_bcd[BCD_W-1:0];
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      op_q    <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state, grant and datapath load logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        // rst gates the grant so req_ready also drops asynchronously.
        if ((|req_valid) && !rst) begin
          req_ready = gnt_onehot;
          id_d      = gnt_idx;
          ptr_d     = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : ID_W'(gnt_idx + 1'b1);
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) op_d = req_bin[i*BIN_W +: BIN_W];
          end
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d   = bcd_c;
        ovf_d   = ovf_c;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_bcd   = bcd_q;
  assign rsp_ovf   = ovf_q;
  assign busy      = (state_q != IDLE);

endmodule
